lsu_port: RTL and testbench
===========================

// Module: lsu_port
// PURPOSE
//  Initiator (core-side) end of the single-port memory interface: turns one
//  RV32 load/store request into one word access (address, 32-bit bit-mask,
//  command, enable), waits for memory_valid, then returns lane-extracted,
//  sign/zero-extended load data. Misaligned accesses and timeouts are
//  reported as errors. Sits between the core execute stage and the memory.
// PARAMETERS
//  TIMEOUT  8'd255  cycles in WAIT without memory_valid before error response
// PORTS
//  clk                   in   1   clock
//  reset                 in   1   synchronous, active-high reset
//  req_valid             in   1   core request present
//  req_ready             out  1   block can accept request (state IDLE)
//  req_write             in   1   1=store, 0=load
//  req_funct3            in   3   RV32 funct3: LB/LH/LW/LBU/LHU, SB/SH/SW
//  req_address           in   32  byte address
//  req_wdata             in   32  store data (low bytes significant)
//  rsp_valid             out  1   one-cycle response strobe
//  rsp_rdata             out  32  extended load data; 0 for stores/errors
//  rsp_error             out  1   misaligned/illegal funct3/timeout (with rsp_valid)
//  memory_ready          in   1   memory accepts enable this edge
//  memory_valid          in   1   access completed (data valid for reads)
//  read_memory_data      in   32  raw read word
//  read_memory_address   out  32  latched byte address
//  write_memory_data     out  32  store data shifted to byte lane
//  write_memory_address  out  32  latched byte address
//  write_memory_mask     out  32  bit mask, 8'hFF per written byte
//  memory_command        out  1   1=write, 0=read
//  memory_enable         out  1   request to memory
// BEHAVIOUR
//  - Reset: state IDLE; every output 0 except req_ready=1 the cycle after.
//  - All outputs registered or decoded from state only; no in->out comb path.
//  - IDLE: req_ready=1. On req_valid: latch write/funct3/address/wdata.
//    Aligned & legal -> ISSUE; else -> RESP with error.
//  - Alignment: H needs addr[0]=0; W needs addr[1:0]=0; B always aligned.
//    Legal funct3: loads 0,1,2,4,5; stores 0,1,2. Others -> error.
//  - ISSUE: memory_enable=1, command/address/data/mask stable. Advance to WAIT
//    at the edge where memory_ready=1; else hold enable (no duplicate access:
//    enable high for exactly the cycles up to and including acceptance).
//  - WAIT: enable=0; timeout counter runs. memory_valid=1 -> capture data,
//    -> RESP. Counter reaching TIMEOUT -> RESP with rsp_error=1.
//  - RESP: rsp_valid=1 for exactly one cycle, then IDLE. Not back-pressured.
//  - Latency (ready=1, memory valid 1 cycle after enable): req accepted edge
//    0, enable cycle 1, memory_valid cycle 2, rsp_valid cycle 3.
//  - Store lanes: k=addr[1:0]. SB: mask=32'hFF<<8k, data=wdata[7:0]<<8k;
//    SH: mask=32'hFFFF<<16*addr[1], data=wdata[15:0]<<16*addr[1]; SW: all 1s.
//    Loads drive write mask and write data 0.
//  - Load extract: byte=rdata>>8k, half=rdata>>16*addr[1]; LB/LH sign-extend,
//    LBU/LHU zero-extend, LW passthrough.
//  - memory_valid outside WAIT is ignored (stray/after-reset completions).
//  - Reset mid-access: immediate IDLE, enable drops, no rsp_valid emitted.
// TESTING
//  - LW 0x8000_0010, memory word 0xDEAD_BEEF -> enable cycle 1, command 0,
//    rsp_valid cycle 3, rsp_rdata=0xDEAD_BEEF, rsp_error=0.
//  - LB 0x8000_0013 on word 0x80FF_0000 -> rsp_rdata=0xFFFF_FF80;
//    LBU same -> 0x0000_0080; LH 0x8000_0012 -> 0xFFFF_80FF.
//  - SB 0x8000_0001 wdata 0x1234_56AB -> mask 0x0000_FF00, data 0x0000_AB00,
//    command 1; SH 0x8000_0002 -> mask 0xFFFF_0000.
//  - LW 0x8000_0002 -> no memory_enable ever, rsp_valid cycle 1 with
//    rsp_error=1, rsp_rdata=0.
//  - memory_ready held 0 for 4 cycles -> enable stays high 5 cycles, one
//    access only; memory_valid never -> rsp_error after TIMEOUT WAIT cycles.
//  - reset asserted in WAIT, memory_valid next cycle -> no rsp_valid, IDLE.

Source files
------------

// File: rtl/lsu_port.sv
// -----------------------------------------------------------------------------
// lsu_port
//   Core-side initiator of the single-port memory interface. Accepts one RV32
//   load/store request at a time, issues a single word access with a byte-lane
//   bit mask, waits for the memory to complete it, then returns the
//   lane-extracted and sign/zero-extended load data as a one-cycle response.
//   Misaligned accesses, illegal funct3 codes and memory timeouts are returned
//   as error responses.
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   req_valid_i/req_ready_o   request handshake (ready only while idle)
//   req_write_i               1 = store, 0 = load
//   req_funct3_i              RV32 funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_address_i             byte address
//   req_wdata_i               store data, low bytes significant
//   rsp_valid_o               one-cycle response strobe
//   rsp_rdata_o               extended load data, 0 for stores and errors
//   rsp_error_o               misaligned / illegal funct3 / timeout
//   memory_ready_i            memory accepts the enable at this edge
//   memory_valid_i            access completed (read data valid)
//   read_memory_data_i        raw read word
//   read_memory_address_o     latched byte address
//   write_memory_data_o       store data shifted onto its byte lane(s)
//   write_memory_address_o    latched byte address
//   write_memory_mask_o       bit mask, 8'hFF per written byte
//   memory_command_o          1 = write, 0 = read
//   memory_enable_o           access request to memory
//
// Every output is either a register or a decode of the state register, so
// there is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module lsu_port #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_address_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_error_o,
    input  logic        memory_ready_i,
    input  logic        memory_valid_i,
    input  logic [31:0] read_memory_data_i,
    output logic [31:0] read_memory_address_o,
    output logic [31:0] write_memory_data_o,
    output logic [31:0] write_memory_address_o,
    output logic [31:0] write_memory_mask_o,
    output logic        memory_command_o,
    output logic        memory_enable_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state_q;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] mask_q;
    logic [31:0] rdata_q;
    logic        error_q;
    logic [7:0]  timer_q;

    logic        req_legal_d;
    logic        req_aligned_d;
    logic [31:0] store_mask_d;
    logic [31:0] store_data_d;
    logic [31:0] load_data_d;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Request decode: legality, alignment and store lane placement. These are
    // only consumed in IDLE, when the request fields are latched.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path can
        // leave it unassigned; otherwise synthesis infers a latch.
        req_legal_d   = 1'b0;
        req_aligned_d = 1'b1;
        store_mask_d  = '0;
        store_data_d  = '0;

        case (req_funct3_i)
            3'd0, 3'd1, 3'd2: req_legal_d = 1'b1;
            3'd4, 3'd5:       req_legal_d = !req_write_i;  // LBU/LHU have no store form
            default:          req_legal_d = 1'b0;
        endcase

        case (req_funct3_i[1:0])
            2'd1:    req_aligned_d = !req_address_i[0];
            2'd2:    req_aligned_d = (req_address_i[1:0] == 2'b00);
            default: req_aligned_d = 1'b1;
        endcase

        // Loads leave mask and data at zero.
        if (req_write_i) begin
            case (req_funct3_i[1:0])
                2'd0: begin
                    store_mask_d = 32'h0000_00FF << {req_address_i[1:0], 3'b000};
                    store_data_d = {24'h0, req_wdata_i[7:0]} << {req_address_i[1:0], 3'b000};
                end
                2'd1: begin
                    store_mask_d = 32'h0000_FFFF << {req_address_i[1], 4'b0000};
                    store_data_d = {16'h0, req_wdata_i[15:0]} << {req_address_i[1], 4'b0000};
                end
                default: begin
                    store_mask_d = 32'hFFFF_FFFF;
                    store_data_d = req_wdata_i;
                end
            endcase
        end
    end

    // Load lane extraction from the raw word using the latched address.
    assign load_byte = read_memory_data_i[{addr_q[1:0], 3'b000} +: 8];
    assign load_half = read_memory_data_i[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        load_data_d = '0;
        case (funct3_q)
            3'd0:    load_data_d = {{24{load_byte[7]}}, load_byte};
            3'd1:    load_data_d = {{16{load_half[15]}}, load_half};
            3'd2:    load_data_d = read_memory_data_i;
            3'd4:    load_data_d = {24'h0, load_byte};
            3'd5:    load_data_d = {16'h0, load_half};
            default: load_data_d = '0;
        endcase
    end

    // Single FSM holding all state; reset aborts any access in flight without
    // producing a response.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset_i) begin
            state_q  <= S_IDLE;
            write_q  <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mask_q   <= '0;
            rdata_q  <= '0;
            error_q  <= 1'b0;
            timer_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        write_q  <= req_write_i;
                        funct3_q <= req_funct3_i;
                        addr_q   <= req_address_i;
                        wdata_q  <= store_data_d;
                        mask_q   <= store_mask_d;
                        rdata_q  <= '0;
                        timer_q  <= '0;
                        if (req_legal_d && req_aligned_d) begin
                            error_q <= 1'b0;
                            state_q <= S_ISSUE;
                        end else begin
                            // Rejected without touching memory.
                            error_q <= 1'b1;
                            state_q <= S_RESP;
                        end
                    end
                end
                S_ISSUE: begin
                    // Enable is held until the memory accepts it, exactly once.
                    if (memory_ready_i) begin
                        timer_q <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Completion wins over a timeout expiring at the same edge.
                    if (memory_valid_i) begin
                        rdata_q <= write_q ? 32'h0 : load_data_d;
                        state_q <= S_RESP;
                    end else if (timer_q == TIMEOUT - 8'd1) begin
                        error_q <= 1'b1;
                        state_q <= S_RESP;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o            = (state_q == S_IDLE);
    assign memory_enable_o        = (state_q == S_ISSUE);
    assign rsp_valid_o            = (state_q == S_RESP);
    assign rsp_rdata_o            = rdata_q;
    assign rsp_error_o            = error_q;
    assign memory_command_o       = write_q;
    assign read_memory_address_o  = addr_q;
    assign write_memory_address_o = addr_q;
    assign write_memory_data_o    = wdata_q;
    assign write_memory_mask_o    = mask_q;

endmodule

// File: tb/tb_lsu_port.sv
// -----------------------------------------------------------------------------
// tb_lsu_port
//   Directed bench for lsu_port. A behavioural model derives, from the RV32
//   load/store rules, the expected memory-side fields and response for each
//   request; a compare process checks the DUT against it on every cycle the
//   outputs carry meaning. Each transaction also checks cycle-level timing,
//   and literal values pin both the model and the DUT for the listed cases.
// -----------------------------------------------------------------------------
module tb_lsu_port;

    localparam logic [7:0] TIMEOUT = 8'd255;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_address_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_error_o;
    logic        memory_ready_i;
    logic        memory_valid_i;
    logic [31:0] read_memory_data_i;
    logic [31:0] read_memory_address_o;
    logic [31:0] write_memory_data_o;
    logic [31:0] write_memory_address_o;
    logic [31:0] write_memory_mask_o;
    logic        memory_command_o;
    logic        memory_enable_o;

    lsu_port #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i                  (clk_i),
        .reset_i                (reset_i),
        .req_valid_i            (req_valid_i),
        .req_ready_o            (req_ready_o),
        .req_write_i            (req_write_i),
        .req_funct3_i           (req_funct3_i),
        .req_address_i          (req_address_i),
        .req_wdata_i            (req_wdata_i),
        .rsp_valid_o            (rsp_valid_o),
        .rsp_rdata_o            (rsp_rdata_o),
        .rsp_error_o            (rsp_error_o),
        .memory_ready_i         (memory_ready_i),
        .memory_valid_i         (memory_valid_i),
        .read_memory_data_i     (read_memory_data_i),
        .read_memory_address_o  (read_memory_address_o),
        .write_memory_data_o    (write_memory_data_o),
        .write_memory_address_o (write_memory_address_o),
        .write_memory_mask_o    (write_memory_mask_o),
        .memory_command_o       (memory_command_o),
        .memory_enable_o        (memory_enable_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Behavioural model: access size in bytes, lane offset in bytes, plain
    // shifts and masks; sign extension by OR-ing the upper bits.
    function automatic void model(input logic wr, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] mw, output bit ok,
                                  output logic [31:0] mask, output logic [31:0] data,
                                  output logic [31:0] rdata);
        int          sz;
        int          sh;
        logic [63:0] low;
        logic [31:0] v;
        ok    = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        sz    = 1 << f3[1:0];
        if (ok && (int'(a[1:0]) % sz) != 0) ok = 1'b0;
        mask  = '0;
        data  = '0;
        rdata = '0;
        if (ok) begin
            sh  = 8 * int'(a[1:0]);
            low = (64'd1 << (8 * sz)) - 64'd1;
            if (wr) begin
                mask = low[31:0] << sh;
                data = (wd & low[31:0]) << sh;
            end else begin
                v = (mw >> sh) & low[31:0];
                if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~low[31:0];
                rdata = v;
            end
        end
    endfunction

    // Expectations for the transaction in flight, written by the driver.
    bit          tb_active = 1'b0;
    bit          exp_ok;
    logic        exp_wr;
    logic [31:0] exp_addr;
    logic [31:0] exp_mask;
    logic [31:0] exp_data;
    logic [31:0] exp_rdata;
    logic        exp_err;
    bit          exp_rsp_allowed;

    // Observations gathered by the driver.
    int          obs_en_first;
    int          obs_en_cnt;
    int          obs_rsp_cyc;
    int          obs_rsp_cnt;
    logic [31:0] obs_rdata;
    logic        obs_err;
    logic [31:0] obs_mask;
    logic [31:0] obs_wdata;
    logic        obs_cmd;

    // Per-cycle compare against the model.
    always @(negedge clk_i) begin
        if (tb_active && !reset_i) begin
            if (memory_enable_o) begin
                check("enable_only_when_legal", {31'b0, memory_enable_o}, {31'b0, exp_ok});
                check("memory_command", {31'b0, memory_command_o}, {31'b0, exp_wr});
                check("read_memory_address", read_memory_address_o, exp_addr);
                check("write_memory_address", write_memory_address_o, exp_addr);
                check("write_memory_mask", write_memory_mask_o, exp_mask);
                check("write_memory_data", write_memory_data_o, exp_data);
            end
            if (rsp_valid_o) begin
                check("rsp_allowed", {31'b0, rsp_valid_o}, {31'b0, exp_rsp_allowed});
                check("rsp_rdata", rsp_rdata_o, exp_rdata);
                check("rsp_error", {31'b0, rsp_error_o}, {31'b0, exp_err});
            end
        end
    end

    // One request from acceptance to response. Cycle n is the interval after
    // clock edge n-1; the request is accepted at edge 0. The memory side
    // stalls acceptance for 'stall' enable cycles, and if 'respond' is set
    // raises memory_valid 'vdelay' cycles after acceptance. reset_at >= 0
    // asserts reset for the edge that ends that cycle.
    task automatic do_txn(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] mw, input int stall,
                          input bit respond, input int vdelay, input int reset_at,
                          input int limit);
        bit          ok;
        logic [31:0] m;
        logic [31:0] d;
        logic [31:0] r;
        int          cyc;
        int          acc_cyc;
        int          exp_rsp_cyc;
        bit          accepted;
        bit          done;

        model(wr, f3, addr, wd, mw, ok, m, d, r);
        @(negedge clk_i);
        exp_ok          = ok;
        exp_wr          = wr;
        exp_addr        = addr;
        exp_mask        = m;
        exp_data        = d;
        exp_err         = !ok || !respond;
        exp_rdata       = (ok && respond) ? r : 32'h0;
        exp_rsp_allowed = (reset_at < 0);
        obs_en_first    = -1;
        obs_en_cnt      = 0;
        obs_rsp_cyc     = -1;
        obs_rsp_cnt     = 0;
        obs_rdata       = 32'hFFFF_FFFF;
        obs_err         = 1'bx;
        obs_mask        = 32'h5555_5555;
        obs_wdata       = 32'h5555_5555;
        obs_cmd         = 1'bx;
        tb_active       = 1'b1;

        check("req_ready_before_request", {31'b0, req_ready_o}, 32'd1);
        req_valid_i   = 1'b1;
        req_write_i   = wr;
        req_funct3_i  = f3;
        req_address_i = addr;
        req_wdata_i   = wd;

        @(negedge clk_i);
        req_valid_i   = 1'b0;
        req_wdata_i   = 32'h0BAD_0BAD;
        req_address_i = 32'h0BAD_0BAD;
        cyc      = 1;
        acc_cyc  = 0;
        accepted = 1'b0;
        done     = 1'b0;
        while (!done && cyc <= limit) begin
            if (memory_enable_o) begin
                obs_en_cnt++;
                if (obs_en_first < 0) begin
                    obs_en_first = cyc;
                    obs_mask     = write_memory_mask_o;
                    obs_wdata    = write_memory_data_o;
                    obs_cmd      = memory_command_o;
                end
            end
            if (rsp_valid_o) begin
                obs_rsp_cnt++;
                obs_rsp_cyc = cyc;
                obs_rdata   = rsp_rdata_o;
                obs_err     = rsp_error_o;
                done        = 1'b1;
            end
            memory_valid_i     = respond && accepted && (cyc == acc_cyc + vdelay);
            read_memory_data_i = memory_valid_i ? mw : 32'hA5A5_A5A5;
            memory_ready_i     = memory_enable_o && !accepted && (obs_en_cnt > stall);
            if (memory_ready_i) begin
                accepted = 1'b1;
                acc_cyc  = cyc;
            end
            reset_i = (cyc == reset_at);
            if (!done) begin
                @(negedge clk_i);
                cyc++;
            end
        end
        memory_ready_i = 1'b0;
        memory_valid_i = 1'b0;
        reset_i        = 1'b0;

        if (reset_at >= 0) begin
            check("no_rsp_after_reset", obs_rsp_cnt, 32'd0);
            check("single_enable_before_reset", obs_en_cnt, 32'd1);
        end else begin
            if (!ok)          exp_rsp_cyc = 1;
            else if (respond) exp_rsp_cyc = stall + vdelay + 2;
            else              exp_rsp_cyc = stall + int'(TIMEOUT) + 2;
            check("rsp_cycle", obs_rsp_cyc, exp_rsp_cyc);
            check("enable_first_cycle", obs_en_first, ok ? 32'd1 : 32'hFFFF_FFFF);
            check("enable_cycle_count", obs_en_cnt, ok ? stall + 1 : 0);
        end

        @(negedge clk_i);
        check("ready_after_txn", {31'b0, req_ready_o}, 32'd1);
        check("rsp_single_cycle", {31'b0, rsp_valid_o}, 32'd0);
        check("enable_low_after_txn", {31'b0, memory_enable_o}, 32'd0);
        tb_active = 1'b0;
    endtask

    bit          m_ok;
    logic [31:0] m_mask;
    logic [31:0] m_data;
    logic [31:0] m_rdata;

    initial begin
        reset_i            = 1'b1;
        req_valid_i        = 1'b0;
        req_write_i        = 1'b0;
        req_funct3_i       = 3'd0;
        req_address_i      = 32'h0;
        req_wdata_i        = 32'h0;
        memory_ready_i     = 1'b0;
        memory_valid_i     = 1'b0;
        read_memory_data_i = 32'h0;

        // Pin the model to hand-computed values.
        model(1'b0, 3'd0, 32'h8000_0013, 32'h0, 32'h80FF_0000, m_ok, m_mask, m_data, m_rdata);
        check("model_lb", m_rdata, 32'hFFFF_FF80);
        model(1'b0, 3'd4, 32'h8000_0013, 32'h0, 32'h80FF_0000, m_ok, m_mask, m_data, m_rdata);
        check("model_lbu", m_rdata, 32'h0000_0080);
        model(1'b0, 3'd1, 32'h8000_0012, 32'h0, 32'h80FF_0000, m_ok, m_mask, m_data, m_rdata);
        check("model_lh", m_rdata, 32'hFFFF_80FF);
        model(1'b1, 3'd0, 32'h8000_0001, 32'h1234_56AB, 32'h0, m_ok, m_mask, m_data, m_rdata);
        check("model_sb_mask", m_mask, 32'h0000_FF00);
        check("model_sb_data", m_data, 32'h0000_AB00);
        model(1'b0, 3'd2, 32'h8000_0002, 32'h0, 32'h0, m_ok, m_mask, m_data, m_rdata);
        check("model_lw_misaligned", {31'b0, m_ok}, 32'd0);

        // Reset state.
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
        check("reset_req_ready", {31'b0, req_ready_o}, 32'd1);
        check("reset_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata_o, 32'd0);
        check("reset_rsp_error", {31'b0, rsp_error_o}, 32'd0);
        check("reset_enable", {31'b0, memory_enable_o}, 32'd0);
        check("reset_command", {31'b0, memory_command_o}, 32'd0);
        check("reset_mask", write_memory_mask_o, 32'd0);
        check("reset_wdata", write_memory_data_o, 32'd0);
        check("reset_raddr", read_memory_address_o, 32'd0);

        // Stray completion while idle must be ignored.
        memory_valid_i     = 1'b1;
        read_memory_data_i = 32'h1234_5678;
        @(negedge clk_i);
        memory_valid_i = 1'b0;
        check("stray_valid_no_rsp", {31'b0, rsp_valid_o}, 32'd0);
        check("stray_valid_ready", {31'b0, req_ready_o}, 32'd1);

        // Loads, nominal latency.
        do_txn(1'b0, 3'd2, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0, 1'b1, 1, -1, 20);
        check("lw_rdata", obs_rdata, 32'hDEAD_BEEF);
        check("lw_error", {31'b0, obs_err}, 32'd0);
        check("lw_command", {31'b0, obs_cmd}, 32'd0);
        check("lw_rsp_cycle", obs_rsp_cyc, 32'd3);
        do_txn(1'b0, 3'd0, 32'h8000_0013, 32'h0, 32'h80FF_0000, 0, 1'b1, 1, -1, 20);
        check("lb_rdata", obs_rdata, 32'hFFFF_FF80);
        do_txn(1'b0, 3'd4, 32'h8000_0013, 32'h0, 32'h80FF_0000, 0, 1'b1, 1, -1, 20);
        check("lbu_rdata", obs_rdata, 32'h0000_0080);
        do_txn(1'b0, 3'd1, 32'h8000_0012, 32'h0, 32'h80FF_0000, 0, 1'b1, 1, -1, 20);
        check("lh_rdata", obs_rdata, 32'hFFFF_80FF);
        do_txn(1'b0, 3'd5, 32'h8000_0012, 32'h0, 32'h80FF_0000, 0, 1'b1, 1, -1, 20);
        check("lhu_rdata", obs_rdata, 32'h0000_80FF);
        do_txn(1'b0, 3'd0, 32'h8000_0011, 32'h0, 32'h1234_7F56, 0, 1'b1, 3, -1, 20);
        check("lb_positive_slow_valid", obs_rdata, 32'h0000_007F);
        check("lb_slow_rsp_cycle", obs_rsp_cyc, 32'd5);

        // Stores.
        do_txn(1'b1, 3'd0, 32'h8000_0001, 32'h1234_56AB, 32'h0, 0, 1'b1, 1, -1, 20);
        check("sb_mask", obs_mask, 32'h0000_FF00);
        check("sb_data", obs_wdata, 32'h0000_AB00);
        check("sb_command", {31'b0, obs_cmd}, 32'd1);
        check("sb_rdata_zero", obs_rdata, 32'h0);
        do_txn(1'b1, 3'd1, 32'h8000_0002, 32'h1234_56AB, 32'h0, 0, 1'b1, 1, -1, 20);
        check("sh_mask", obs_mask, 32'hFFFF_0000);
        check("sh_data", obs_wdata, 32'h56AB_0000);
        do_txn(1'b1, 3'd2, 32'h8000_0004, 32'hCAFE_F00D, 32'h0, 0, 1'b1, 1, -1, 20);
        check("sw_mask", obs_mask, 32'hFFFF_FFFF);
        check("sw_data", obs_wdata, 32'hCAFE_F00D);

        // Rejected requests: no memory access, error on cycle 1.
        do_txn(1'b0, 3'd2, 32'h8000_0002, 32'h0, 32'hDEAD_BEEF, 0, 1'b1, 1, -1, 20);
        check("lw_misaligned_error", {31'b0, obs_err}, 32'd1);
        check("lw_misaligned_rdata", obs_rdata, 32'h0);
        check("lw_misaligned_rsp_cycle", obs_rsp_cyc, 32'd1);
        check("lw_misaligned_no_enable", obs_en_cnt, 32'd0);
        do_txn(1'b1, 3'd1, 32'h8000_0003, 32'hFFFF_FFFF, 32'h0, 0, 1'b1, 1, -1, 20);
        check("sh_misaligned_error", {31'b0, obs_err}, 32'd1);
        do_txn(1'b0, 3'd3, 32'h8000_0000, 32'h0, 32'h0, 0, 1'b1, 1, -1, 20);
        check("load_f3_3_error", {31'b0, obs_err}, 32'd1);
        do_txn(1'b1, 3'd4, 32'h8000_0000, 32'h1111_1111, 32'h0, 0, 1'b1, 1, -1, 20);
        check("store_f3_4_error", {31'b0, obs_err}, 32'd1);

        // Back-pressure: ready low for 4 enable cycles.
        do_txn(1'b0, 3'd2, 32'h8000_0020, 32'h0, 32'h0F0F_1234, 4, 1'b1, 1, -1, 30);
        check("stall_enable_cycles", obs_en_cnt, 32'd5);
        check("stall_rdata", obs_rdata, 32'h0F0F_1234);
        check("stall_rsp_cycle", obs_rsp_cyc, 32'd7);

        // Timeout: memory never completes.
        do_txn(1'b0, 3'd2, 32'h8000_0030, 32'h0, 32'h0, 2, 1'b0, 1, -1, 400);
        check("timeout_error", {31'b0, obs_err}, 32'd1);
        check("timeout_rdata", obs_rdata, 32'h0);
        check("timeout_rsp_cycle", obs_rsp_cyc, 32'd259);

        // Reset while waiting, completion arrives the cycle after reset.
        do_txn(1'b0, 3'd2, 32'h8000_0040, 32'h0, 32'h7777_7777, 0, 1'b1, 2, 2, 8);

        // Normal operation after the aborted access.
        do_txn(1'b0, 3'd1, 32'h8000_0046, 32'h0, 32'h7FFE_0001, 0, 1'b1, 1, -1, 20);
        check("after_reset_lh_rdata", obs_rdata, 32'h0000_7FFE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
